// File: rtl/binary_dot_accum.sv
`default_nettype none
// ============================================================================
// Module   : binary_dot_accum
// Purpose  : Binary-weight (+1/-1) multi-beat dot-product accumulator with a
//            saturated signed result; optional ReLU via BINARY_DOT_ACCUM_RELU_EN.
// Revision : 1.0
// ============================================================================
module binary_dot_accum #(
    parameter int LANES     = 16,
    parameter int DW        = 16,
    parameter int MAX_BEATS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES-1:0][DW-1:0]   input_neuron,
    input  logic [LANES-1:0]           weight_bits,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [DW-1:0]              FinalOut,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       ovf
);

    localparam int LW  = $clog2(LANES);
    localparam int BSW = DW + 1 + LW;
    localparam int AW  = BSW + $clog2(MAX_BEATS);
    localparam int FW  = AW + 1;
    localparam int CW  = $clog2(MAX_BEATS + 2);

    localparam logic [CW-1:0]        CNT_MAX  = CW'(MAX_BEATS);
    localparam logic [CW-1:0]        CNT_SAT  = CW'(MAX_BEATS + 1);
    localparam logic signed [FW-1:0] SAT_MAX  = {{(FW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [FW-1:0] SAT_MIN  = {{(FW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic                   s1_valid_q;
    logic                   s1_last_q;
    logic signed [BSW-1:0]  s1_sum_q;
    logic signed [AW-1:0]   acc_q;
    logic                   first_q;
    logic [CW-1:0]          cnt_q;
    logic [DW-1:0]          final_q;
    logic                   out_valid_q;
    logic                   ovf_q;

    logic signed [DW:0]     term;
    logic signed [BSW-1:0]  beat_sum;
    logic signed [AW-1:0]   acc_base;
    logic signed [AW-1:0]   acc_d;
    logic signed [FW-1:0]   final_sum;
    logic signed [FW-1:0]   final_relu;
    logic                   sat_hi;
    logic                   sat_lo;
    logic [DW-1:0]          final_d;
    logic [CW-1:0]          cnt_d;
    logic                   accept;
    logic                   s2_fire;
    logic                   ovf_d;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign s2_fire   = in_ready && s1_valid_q;
    assign FinalOut  = final_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

    always_comb begin
        beat_sum = '0;
        term     = '0;
        for (int i = 0; i < LANES; i++) begin
            term = $signed({input_neuron[i][DW-1], input_neuron[i]});
            if (!weight_bits[i]) begin
                term = -term;
            end
            beat_sum = beat_sum + BSW'(term);
        end
    end

    // A first beat loads the accumulator instead of adding to stale content.
    assign acc_base  = first_q ? '0 : acc_q;
    assign acc_d     = acc_base + AW'(s1_sum_q);
    assign final_sum = FW'(acc_base) + FW'(s1_sum_q);

`ifdef BINARY_DOT_ACCUM_RELU_EN
    assign final_relu = final_sum[FW-1] ? '0 : final_sum;
`else
    assign final_relu = final_sum;
`endif

    assign sat_hi  = final_relu > SAT_MAX;
    assign sat_lo  = final_relu < SAT_MIN;
    assign final_d = sat_hi ? SAT_MAX[DW-1:0] :
                     sat_lo ? SAT_MIN[DW-1:0] : final_relu[DW-1:0];

    assign cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    assign ovf_d = ovf_q
                 | (accept && (cnt_d > CNT_MAX))
                 | (s2_fire && s1_last_q && (sat_hi || sat_lo));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_sum_q    <= '0;
            acc_q       <= '0;
            first_q     <= 1'b1;
            cnt_q       <= '0;
            final_q     <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            if (accept) begin
                cnt_q <= in_last ? '0 : cnt_d;
            end
            // Everything downstream of the input freezes while a result is stalled.
            if (in_ready) begin
                s1_valid_q  <= in_valid;
                if (in_valid) begin
                    s1_sum_q  <= beat_sum;
                    s1_last_q <= in_last;
                end
                out_valid_q <= s1_valid_q && s1_last_q;
                if (s1_valid_q) begin
                    if (s1_last_q) begin
                        final_q <= final_d;
                        first_q <= 1'b1;
                    end else begin
                        acc_q   <= acc_d;
                        first_q <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_binary_dot_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_binary_dot_accum
// Purpose  : Directed, table-driven self-checking bench for binary_dot_accum.
// Revision : 1.0
// ============================================================================
module tb_binary_dot_accum;

    localparam int LANES     = 16;
    localparam int DW        = 16;
    localparam int MAX_BEATS = 16;
`ifdef BINARY_DOT_ACCUM_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic [LANES-1:0][DW-1:0] input_neuron;
    logic [LANES-1:0]         weight_bits;
    logic                     in_valid;
    logic                     in_last;
    logic                     in_ready;
    logic [DW-1:0]            FinalOut;
    logic                     out_valid;
    logic                     out_ready;
    logic                     ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    binary_dot_accum #(.LANES(LANES), .DW(DW), .MAX_BEATS(MAX_BEATS)) dut (
        .clk(clk), .rst(rst), .input_neuron(input_neuron), .weight_bits(weight_bits),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .FinalOut(FinalOut), .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
    );

    typedef struct {
        string       name;
        bit          idx;
        logic [15:0] val;
        logic [15:0] wts;
        int          beats;
        logic [15:0] exp_out;
        bit          exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit idx, input logic [15:0] val, input logic [15:0] wts,
                         input bit v, input bit last);
        for (int i = 0; i < LANES; i++) begin
            input_neuron[i] = idx ? 16'(i) : val;
        end
        weight_bits = wts;
        in_valid    = v;
        in_last     = last;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic send(input bit idx, input logic [15:0] val, input logic [15:0] wts,
                        input int beats);
        for (int b = 0; b < beats; b++) begin
            drive(idx, val, wts, 1'b1, b == beats - 1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 8) begin
            step();
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: out_valid timeout got 0 expected 1", name);
        end
    endtask

    vec_t vecs[13];
    logic [15:0] neg8;

    initial begin
        neg8 = RELU ? 16'h0000 : 16'hFFF8;
        vecs[0]  = '{"neg8",     1'b1, 16'h0000, 16'h5555, 1,  neg8,                           1'b0};
        vecs[1]  = '{"pos360",   1'b1, 16'h0000, 16'hFFFF, 3,  16'h0168,                       1'b0};
        vecs[2]  = '{"sat_max",  1'b0, 16'h7FFF, 16'hFFFF, 2,  16'h7FFF,                       1'b1};
        vecs[3]  = '{"sat_min",  1'b0, 16'h8000, 16'hFFFF, 2,  RELU ? 16'h0000 : 16'h8000,     !RELU};
        vecs[4]  = '{"neg_min",  1'b0, 16'h8000, 16'h0000, 1,  16'h7FFF,                       1'b1};
        vecs[5]  = '{"all_neg",  1'b1, 16'h0000, 16'h0000, 1,  RELU ? 16'h0000 : 16'hFF88,     1'b0};
        vecs[6]  = '{"cancel16", 1'b0, 16'h0001, 16'hAAAA, 16, 16'h0000,                       1'b0};
        vecs[7]  = '{"full16",   1'b0, 16'h0010, 16'hFFFF, 16, 16'h1000,                       1'b0};
        vecs[8]  = '{"beats17",  1'b0, 16'h0001, 16'hFFFF, 17, 16'h0110,                       1'b1};
        vecs[9]  = '{"minus1x4", 1'b0, 16'hFFFF, 16'hFFFF, 4,  RELU ? 16'h0000 : 16'hFFC0,     1'b0};
        vecs[10] = '{"edge_hi",  1'b0, 16'h0800, 16'hFFFF, 1,  16'h7FFF,                       1'b1};
        vecs[11] = '{"edge_lo",  1'b0, 16'hF800, 16'hFFFF, 1,  RELU ? 16'h0000 : 16'h8000,     1'b0};
        vecs[12] = '{"just_hi",  1'b0, 16'h07FF, 16'hFFFF, 1,  16'h7FF0,                       1'b0};

        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_final",     32'(FinalOut),  32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        for (int v = 0; v < 13; v++) begin
            do_reset();
            send(vecs[v].idx, vecs[v].val, vecs[v].wts, vecs[v].beats);
            wait_out(vecs[v].name);
            check({vecs[v].name, "_out"}, 32'(FinalOut), 32'(vecs[v].exp_out));
            check({vecs[v].name, "_ovf"}, 32'(ovf),      32'(vecs[v].exp_ovf));
        end

        // Two-edge latency and back-to-back results with no bubble.
        do_reset();
        drive(1'b1, 16'h0, 16'hFFFF, 1'b1, 1'b1);
        step();
        check("lat_not_yet", 32'(out_valid), 32'd0);
        drive(1'b1, 16'h0, 16'h5555, 1'b1, 1'b1);
        step();
        check("b2b_a_valid", 32'(out_valid), 32'd1);
        check("b2b_a_out",   32'(FinalOut),  32'h0078);
        drive(1'b1, 16'h0, 16'h5555, 1'b0, 1'b0);
        step();
        check("b2b_b_valid", 32'(out_valid), 32'd1);
        check("b2b_b_out",   32'(FinalOut),  32'(neg8));
        step();
        check("b2b_drop",    32'(out_valid), 32'd0);

        // Idle cycles between beats must not disturb the partial sum.
        do_reset();
        drive(1'b1, 16'h0, 16'hFFFF, 1'b1, 1'b0); step();
        drive(1'b1, 16'h0, 16'hFFFF, 1'b0, 1'b0); step(); step();
        drive(1'b1, 16'h0, 16'hFFFF, 1'b1, 1'b0); step();
        drive(1'b1, 16'h0, 16'hFFFF, 1'b0, 1'b0); step();
        drive(1'b1, 16'h0, 16'hFFFF, 1'b1, 1'b1); step();
        drive(1'b1, 16'h0, 16'hFFFF, 1'b0, 1'b0);
        wait_out("bubble");
        check("bubble_out", 32'(FinalOut), 32'h0168);

        // Output backpressure with a new beat waiting at the input.
        do_reset();
        out_ready = 1'b0;
        send(1'b1, 16'h0, 16'hFFFF, 3);
        wait_out("bp_first");
        drive(1'b1, 16'h0, 16'h5555, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_final",     32'(FinalOut),  32'h0168);
            step();
        end
        out_ready = 1'b1;
        step();
        drive(1'b1, 16'h0, 16'h5555, 1'b0, 1'b0);
        wait_out("bp_second");
        check("bp_next_out", 32'(FinalOut), 32'(neg8));
        check("bp_ovf",      32'(ovf),      32'd0);

        // Asynchronous reset in the middle of a product clears all state.
        do_reset();
        send(1'b0, 16'h7FFF, 16'hFFFF, 2);
        wait_out("mid_pre");
        send(1'b1, 16'h0, 16'hFFFF, 1);
        drive(1'b1, 16'h0, 16'hFFFF, 1'b1, 1'b0);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_final", 32'(FinalOut),  32'd0);
        check("mid_rst_ovf",   32'(ovf),       32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        send(1'b1, 16'h0, 16'h5555, 1);
        wait_out("mid_post");
        check("mid_post_out", 32'(FinalOut), 32'(neg8));
        check("mid_post_ovf", 32'(ovf),      32'd0);

        // Beat-count overflow flags exactly on the 17th accept.
        do_reset();
        for (int b = 0; b < 16; b++) begin
            drive(1'b0, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
            step();
        end
        check("cnt16_ovf", 32'(ovf), 32'd0);
        drive(1'b0, 16'h0001, 16'hFFFF, 1'b1, 1'b1);
        step();
        check("cnt17_ovf", 32'(ovf), 32'd1);
        in_valid = 1'b0;
        wait_out("cnt17");
        check("cnt17_out", 32'(FinalOut), 32'h0110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
